// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
// Operation and state encodings plus the fixed iteration count.
package mult_div_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   localparam int ITERATIONS = 32;
   localparam int COUNT_W    = $clog2(ITERATIONS);

   function automatic logic op_is_div(op_e op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   function automatic logic op_is_signed(op_e op);
      return op inside {OP_MULT, OP_DIV};
   endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Combinational sign handling: operand magnitudes in, signed results out.
// Products negate as one 64-bit value; quotient/remainder negate separately.
module mult_div_sign_fix
   import mult_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            operation,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic [DATA_WIDTH-1:0] magnitude_a,
   output logic [DATA_WIDTH-1:0] magnitude_b,
   output logic                  sign_a,
   output logic                  sign_b,
   input  logic                  result_is_div,
   input  logic                  negate_low,
   input  logic                  negate_high,
   input  logic [DATA_WIDTH-1:0] raw_hi,
   input  logic [DATA_WIDTH-1:0] raw_lo,
   output logic [DATA_WIDTH-1:0] fixed_hi,
   output logic [DATA_WIDTH-1:0] fixed_lo
);

   logic                    signed_op;
   logic [2*DATA_WIDTH-1:0] product;
   logic [2*DATA_WIDTH-1:0] product_neg;

   // Operand magnitudes and sign extraction for signed operations
   always_comb begin
      signed_op   = op_is_signed(op_e'(operation));
      sign_a      = signed_op & operand_a[DATA_WIDTH-1];
      sign_b      = signed_op & operand_b[DATA_WIDTH-1];
      magnitude_a = sign_a ? -operand_a : operand_a;
      magnitude_b = sign_b ? -operand_b : operand_b;
   end

   // Result negation: whole product, or quotient and remainder apart
   always_comb begin
      product     = {raw_hi, raw_lo};
      product_neg = -product;
      fixed_hi    = raw_hi;
      fixed_lo    = raw_lo;
      if (result_is_div) begin
         fixed_lo = negate_low  ? -raw_lo : raw_lo;
         fixed_hi = negate_high ? -raw_hi : raw_hi;
      end else if (negate_low) begin
         {fixed_hi, fixed_lo} = product_neg;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            operation,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  write_hi,
   input  logic                  write_lo,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  busy,
   output logic                  done,
   output logic                  divide_by_zero,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W = DATA_WIDTH;

   state_e             state;
   state_e             state_next;
   logic [COUNT_W-1:0] count;
   logic               is_div;
   logic               neg_low;
   logic               neg_high;
   logic               div_zero;
   logic [W-1:0]       divisor;
   logic [2*W-1:0]     acc;
   logic [2*W-1:0]     acc_step;
   logic [W:0]         mul_sum;
   logic [W+1:0]       div_trial;
   logic [W-1:0]       mag_a;
   logic [W-1:0]       mag_b;
   logic               sign_a;
   logic               sign_b;
   logic [W-1:0]       fixed_hi;
   logic [W-1:0]       fixed_lo;
   logic               start_div;
   logic               start_zero;

   assign busy       = (state != ST_IDLE);
   assign start_div  = op_is_div(op_e'(operation));
   assign start_zero = start_div && (operand_b == '0);

   mult_div_sign_fix #(
      .DATA_WIDTH (W)
   ) u_sign_fix (
      .operation     (operation),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .magnitude_a   (mag_a),
      .magnitude_b   (mag_b),
      .sign_a        (sign_a),
      .sign_b        (sign_b),
      .result_is_div (is_div),
      .negate_low    (neg_low),
      .negate_high   (neg_high),
      .raw_hi        (acc[2*W-1:W]),
      .raw_lo        (acc[W-1:0]),
      .fixed_hi      (fixed_hi),
      .fixed_lo      (fixed_lo)
   );

   // Sequencer next state: IDLE -> RUN (32 steps) -> FIX -> IDLE
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (count == COUNT_W'(ITERATIONS - 1)) state_next = ST_FIX;
         ST_FIX:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // One radix-2 step; a zero divisor always "fits" so the quotient fills with ones
   always_comb begin
      mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divisor} : '0);
      div_trial = {1'b0, acc[2*W-1:W-1]} - {2'b00, divisor};
      acc_step  = {mul_sum, acc[W-1:1]};
      if (is_div) begin
         if (!div_trial[W+1]) acc_step = {div_trial[W-1:0], acc[W-2:0], 1'b1};
         else                 acc_step = {acc[2*W-2:0], 1'b0};
      end
   end

   // Datapath, HI/LO architectural registers and status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         count          <= '0;
         acc            <= '0;
         divisor        <= '0;
         is_div         <= 1'b0;
         neg_low        <= 1'b0;
         neg_high       <= 1'b0;
         div_zero       <= 1'b0;
         done           <= 1'b0;
         divide_by_zero <= 1'b0;
         hi             <= '0;
         lo             <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (write_hi) hi <= write_data;
               if (write_lo) lo <= write_data;
               if (start) begin
                  count          <= '0;
                  acc            <= {{W{1'b0}}, mag_a};
                  divisor        <= mag_b;
                  is_div         <= start_div;
                  div_zero       <= start_zero;
                  neg_low        <= (sign_a ^ sign_b) && !start_zero;
                  neg_high       <= start_div && sign_a;
                  divide_by_zero <= 1'b0;
               end
            end
            ST_RUN: begin
               acc   <= acc_step;
               count <= count + 1'b1;
            end
            ST_FIX: begin
               hi             <= fixed_hi;
               lo             <= fixed_lo;
               done           <= 1'b1;
               divide_by_zero <= div_zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops.
// Expected HI/LO come from plain 64-bit arithmetic, not the radix-2 datapath.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  operation;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        write_hi;
   logic        write_lo;
   logic [31:0] write_data;
   logic        busy;
   logic        done;
   logic        divide_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          due;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   exp_t prev;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   mult_div_unit #(.DATA_WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .operation      (operation),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .write_hi       (write_hi),
      .write_lo       (write_lo),
      .write_data     (write_data),
      .busy           (busy),
      .done           (done),
      .divide_by_zero (divide_by_zero),
      .hi             (hi),
      .lo             (lo)
   );

   always #5 clock = ~clock;

   // Edge counter: number of rising edges seen so far
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t            e;
      longint          p;
      longint          sa;
      longint          sb;
      longint unsigned pu;
      e.dbz = 1'b0;
      e.due = 0;
      e.hi  = '0;
      e.lo  = '0;
      case (op)
         2'b00: begin
            p    = longint'($signed(a)) * longint'($signed(b));
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b01: begin
            pu   = {32'b0, a} * {32'b0, b};
            e.hi = pu[63:32];
            e.lo = pu[31:0];
         end
         2'b10: begin
            if (b == 0) begin
               e.hi  = a;
               e.lo  = 32'hFFFF_FFFF;
               e.dbz = 1'b1;
            end else begin
               sa   = longint'($signed(a));
               sb   = longint'($signed(b));
               p    = sa / sb;
               e.lo = p[31:0];
               p    = sa % sb;
               e.hi = p[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               e.hi  = a;
               e.lo  = 32'hFFFF_FFFF;
               e.dbz = 1'b1;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding op
   always @(negedge clock) begin
      if (!reset && done) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending op");
         end else begin
            mon_e = expq.pop_front();
            check("hi", hi, mon_e.hi);
            check("lo", lo, mon_e.lo);
            check("dbz", {31'b0, divide_by_zero}, {31'b0, mon_e.dbz});
            check("done_edge", 32'(cyc), 32'(mon_e.due));
         end
      end
   end

   // Called at a negedge; drives start for one cycle once the unit is idle
   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      exp_t e;
      int   n = 0;
      while (busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: got busy=1 expected idle");
         return;
      end
      operation = op;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      e         = model(op, a, b);
      e.due     = cyc + 1 + 33;
      expq.push_back(e);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (expq.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (expq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL wait_timeout: got %0d pending expected 0", expq.size());
         expq.delete();
      end
      @(negedge clock);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int bc;
      int n;
      reset      = 1'b1;
      start      = 1'b0;
      operation  = 2'b00;
      operand_a  = '0;
      operand_b  = '0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      write_data = '0;
      repeat (2) @(negedge clock);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_dbz", {31'b0, divide_by_zero}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bc = 0;
      n  = 0;
      while (!done && n < 100) begin
         if (busy) bc++;
         @(negedge clock);
         n++;
      end
      check("busy_cycles", 32'(bc), 32'd33);
      wait_idle();

      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
      wait_idle();
      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_idle();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();

      issue(2'b11, 32'h0000_0064, 32'h0000_0000);
      wait_idle();
      check("dbz_held", {31'b0, divide_by_zero}, 32'd1);
      issue(2'b01, 32'd2, 32'd3);
      check("dbz_cleared", {31'b0, divide_by_zero}, 32'd0);
      wait_idle();

      prev = model(2'b01, 32'd2, 32'd3);
      issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (5) @(negedge clock);
      operation  = 2'b10;
      operand_a  = 32'd100;
      operand_b  = 32'd7;
      start      = 1'b1;
      write_hi   = 1'b1;
      write_data = 32'h0000_1234;
      @(negedge clock);
      start    = 1'b0;
      write_hi = 1'b0;
      check("hi_busy_write", hi, prev.hi);
      check("busy_kept", {31'b0, busy}, 32'd1);
      wait_idle();

      write_hi   = 1'b1;
      write_data = 32'hA5A5_0F0F;
      @(negedge clock);
      write_hi   = 1'b0;
      check("mthi", hi, 32'hA5A5_0F0F);
      write_lo   = 1'b1;
      write_data = 32'h0102_0304;
      @(negedge clock);
      write_lo   = 1'b0;
      check("mtlo", lo, 32'h0102_0304);
      check("mtlo_hi_kept", hi, 32'hA5A5_0F0F);

      write_lo   = 1'b1;
      write_data = 32'hDEAD_BEEF;
      issue(2'b11, 32'd1000, 32'd33);
      write_lo = 1'b0;
      check("mtlo_with_start", lo, 32'hDEAD_BEEF);
      wait_idle();

      issue(2'b00, 32'h0001_2345, 32'hFFFF_8000);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      expq.delete();
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      repeat (40) @(negedge clock);
      issue(2'b00, 32'h0000_0011, 32'hFFFF_FFFE);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom_range(0, 3)), pick(), pick());
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
